// File: rtl/mw_mem_access_if.sv
// Bundle of the MW memory-access signals: pipeline-side inputs, data-cache
// request/response and writeback results. The pipeline (or bench) uses the
// master modport and the access unit uses the slave modport.
interface mw_mem_access_if #(parameter int DWIDTH = 32);
  // Pipeline side
  logic              valid_in;
  logic              re;
  logic [3:0]        w_mask;
  logic [2:0]        funct3;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] store_data;
  // Data cache side
  logic [DWIDTH-1:0] dcache_addr;
  logic [DWIDTH-1:0] dcache_din;
  logic [3:0]        dcache_we;
  logic              dcache_re;
  logic [DWIDTH-1:0] dcache_dout;
  logic              dcache_stall;
  // Results
  logic [DWIDTH-1:0] load_data;
  logic              load_valid;
  logic              mem_stall;
  logic              misaligned;
  logic [31:0]       stall_count;
  // FSM state for observation (0 = IDLE, 1 = LD_WAIT)
  logic              state_dbg;

  modport master (
    output valid_in, re, w_mask, funct3, addr, store_data,
    output dcache_dout, dcache_stall,
    input  dcache_addr, dcache_din, dcache_we, dcache_re,
    input  load_data, load_valid, mem_stall, misaligned, stall_count, state_dbg
  );

  modport slave (
    input  valid_in, re, w_mask, funct3, addr, store_data,
    input  dcache_dout, dcache_stall,
    output dcache_addr, dcache_din, dcache_we, dcache_re,
    output load_data, load_valid, mem_stall, misaligned, stall_count, state_dbg
  );
endinterface

// File: rtl/mw_mem_access.sv
// MW-stage data-memory access unit: aligns stores into byte lanes, issues
// cache requests, holds the pipeline while a load is outstanding, extends
// load data for writeback, flags misaligned accesses and counts stall cycles.
//
// Handshake: a request is offered in IDLE and is taken by the cache on any
// cycle where dcache_stall is low; a load response is taken in LD_WAIT on the
// first cycle dcache_stall is low. While a request/response is not taken the
// unit keeps mem_stall high so the pipeline holds the same instruction.
module mw_mem_access #(
  parameter int DWIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mw_mem_access_if.slave bus
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_LD_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [1:0]        off;
  logic              is_store, access, is_half, is_word, misal;
  logic [DWIDTH-1:0] word_sh;
  logic [DWIDTH-1:0] ext_data;

  logic [DWIDTH-1:0] dc_addr_c, dc_din_c, load_data_c;
  logic [3:0]        dc_we_c;
  logic              dc_re_c, load_valid_c, mem_stall_c, misaligned_c;

  // Access classification and misalignment check for the current instruction
  always_comb begin
    off      = bus.addr[1:0];
    is_store = |bus.w_mask;
    access   = bus.valid_in & (bus.re | is_store);
    is_half  = (bus.funct3[1:0] == 2'b01) | (bus.w_mask == 4'b0011);
    is_word  = (bus.funct3[1:0] == 2'b10) | (bus.w_mask == 4'b1111);
    misal    = (is_half & off[0]) | (is_word & (off != 2'b00));
  end

  // Load extraction from the captured byte offset and width/sign code
  always_comb begin
    word_sh = bus.dcache_dout >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_data = {{24{word_sh[7]}}, word_sh[7:0]};
      3'b001:  ext_data = {{16{word_sh[15]}}, word_sh[15:0]};
      3'b100:  ext_data = {24'd0, word_sh[7:0]};
      3'b101:  ext_data = {16'd0, word_sh[15:0]};
      default: ext_data = word_sh;
    endcase
  end

  // FSM next state and request/response outputs
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    f3_d         = f3_q;
    dc_addr_c    = '0;
    dc_din_c     = '0;
    dc_we_c      = 4'b0000;
    dc_re_c      = 1'b0;
    load_data_c  = '0;
    load_valid_c = 1'b0;
    mem_stall_c  = 1'b0;
    misaligned_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && misal) begin
          misaligned_c = 1'b1;
        end else if (access && bus.re) begin
          // Loads win over a simultaneous store mask; no byte writes issued
          dc_addr_c   = {bus.addr[DWIDTH-1:2], 2'b00};
          dc_re_c     = 1'b1;
          mem_stall_c = 1'b1;
          if (!bus.dcache_stall) begin
            off_d   = off;
            f3_d    = bus.funct3;
            state_d = S_LD_WAIT;
          end
        end else if (access) begin
          dc_addr_c   = {bus.addr[DWIDTH-1:2], 2'b00};
          dc_we_c     = bus.w_mask << off;
          dc_din_c    = bus.store_data << {off, 3'b000};
          mem_stall_c = bus.dcache_stall;
        end
      end
      default: begin
        // Waiting for the load response; the same instruction is still
        // presented upstream, so nothing new is issued here
        if (bus.dcache_stall) begin
          mem_stall_c = 1'b1;
        end else begin
          load_valid_c = 1'b1;
          load_data_c  = ext_data;
          state_d      = S_IDLE;
        end
      end
    endcase
    cnt_d = mem_stall_c ? cnt_q + 32'd1 : cnt_q;
  end

  // State, captured load attributes and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held
  always_comb begin
    bus.dcache_addr = reset ? '0     : dc_addr_c;
    bus.dcache_din  = reset ? '0     : dc_din_c;
    bus.dcache_we   = reset ? 4'b0   : dc_we_c;
    bus.dcache_re   = reset ? 1'b0   : dc_re_c;
    bus.load_data   = reset ? '0     : load_data_c;
    bus.load_valid  = reset ? 1'b0   : load_valid_c;
    bus.mem_stall   = reset ? 1'b0   : mem_stall_c;
    bus.misaligned  = reset ? 1'b0   : misaligned_c;
    bus.stall_count = reset ? 32'd0  : cnt_q;
    bus.state_dbg   = reset ? S_IDLE : state_q;
  end

endmodule

// File: tb/tb_mw_mem_access.sv
// Directed bench for mw_mem_access: a table of single-cycle IDLE vectors
// followed by hand-written multi-cycle load, reset and back-to-back sequences.
module tb_mw_mem_access;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   re_pulses;
  logic [31:0] exp_q[$];

  mw_mem_access_if #(.DWIDTH(32)) bus ();

  mw_mem_access #(.DWIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        re;
    logic [3:0]  wm;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        stall;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [3:0]  e_we;
    logic        e_re;
    logic        e_ms;
    logic        e_mis;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic valid, input logic re, input logic [3:0] wm,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic stall,
                              input logic [31:0] e_addr, input logic [31:0] e_din,
                              input logic [3:0] e_we, input logic e_re,
                              input logic e_ms, input logic e_mis);
    vec_t v;
    v.valid = valid; v.re = re; v.wm = wm; v.f3 = f3; v.addr = addr; v.sd = sd;
    v.stall = stall; v.e_addr = e_addr; v.e_din = e_din; v.e_we = e_we;
    v.e_re = e_re; v.e_ms = e_ms; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic valid, input logic re, input logic [3:0] wm,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic stall);
    bus.valid_in     = valid;
    bus.re           = re;
    bus.w_mask       = wm;
    bus.funct3       = f3;
    bus.addr         = addr;
    bus.store_data   = sd;
    bus.dcache_stall = stall;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 4'b0000, 3'b000, 32'h0, 32'h0, 1'b0);
    bus.dcache_dout = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, bus.dcache_addr, 32'h0);
    chk({tag, "_din"},  bus.dcache_din, 32'h0);
    chk({tag, "_we"},   {28'd0, bus.dcache_we}, 32'h0);
    chk({tag, "_re"},   {31'd0, bus.dcache_re}, 32'h0);
    chk({tag, "_lv"},   {31'd0, bus.load_valid}, 32'h0);
    chk({tag, "_ld"},   bus.load_data, 32'h0);
    chk({tag, "_ms"},   {31'd0, bus.mem_stall}, 32'h0);
    chk({tag, "_mis"},  {31'd0, bus.misaligned}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Scoreboard: a valid load must match the oldest expected load result
  task automatic expect_load(input string tag);
    chk({tag, "_lv"}, {31'd0, bus.load_valid}, 32'h1);
    chk({tag, "_ms"}, {31'd0, bus.mem_stall}, 32'h0);
    chk({tag, "_re"}, {31'd0, bus.dcache_re}, 32'h0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got load with empty expected queue", tag);
    end else begin
      chk({tag, "_data"}, bus.load_data, exp_q.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_in();

    // Outputs while reset is held
    @(negedge clk);
    check_all_zero("in_reset");
    chk("in_reset_cnt", bus.stall_count, 32'h0);
    do_reset();

    // Reset state with no instruction present
    @(negedge clk);
    check_all_zero("post_reset");
    chk("post_reset_cnt", bus.stall_count, 32'h0);
    chk("post_reset_state", {31'd0, bus.state_dbg}, 32'h0);

    // Single-cycle IDLE vectors (none of these enter LD_WAIT)
    vecs[0]  = mk(0, 0, 4'b0000, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 0);
    vecs[1]  = mk(1, 0, 4'b0001, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0000_1000, 32'hAB00_0000, 4'b1000, 0, 0, 0);
    vecs[2]  = mk(1, 0, 4'b1111, 3'b010, 32'h0000_4002, 32'h1111_2222, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1);
    vecs[3]  = mk(1, 1, 4'b0000, 3'b001, 32'h0000_4001, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1);
    vecs[4]  = mk(1, 0, 4'b0011, 3'b001, 32'h0000_4002, 32'h0000_1234, 0, 32'h0000_4000, 32'h1234_0000, 4'b1100, 0, 0, 0);
    vecs[5]  = mk(1, 0, 4'b1111, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 0, 1, 0);
    vecs[6]  = mk(1, 0, 4'b0011, 3'b001, 32'h0000_4001, 32'h0000_5678, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 1);
    vecs[7]  = mk(0, 1, 4'b0000, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 0);
    vecs[8]  = mk(1, 1, 4'b0000, 3'b010, 32'h0000_3004, 32'h0, 1, 32'h0000_3004, 32'h0, 4'b0000, 1, 1, 0);
    vecs[9]  = mk(1, 1, 4'b1111, 3'b010, 32'h0000_3008, 32'hFFFF_FFFF, 1, 32'h0000_3008, 32'h0, 4'b0000, 1, 1, 0);
    vecs[10] = mk(1, 0, 4'b0001, 3'b000, 32'h0000_1001, 32'h0000_0055, 0, 32'h0000_1000, 32'h0000_5500, 4'b0010, 0, 0, 0);
    vecs[11] = mk(1, 0, 4'b0001, 3'b000, 32'h0000_0002, 32'hFFFF_FF77, 0, 32'h0000_0000, 32'hFF77_0000, 4'b0100, 0, 0, 0);
    vecs[12] = mk(1, 0, 4'b0000, 3'b010, 32'h0000_0003, 32'h1234_5678, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].re, vecs[i].wm, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].stall);
      @(negedge clk);
      chk($sformatf("v%0d_addr", i), bus.dcache_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_din", i),  bus.dcache_din, vecs[i].e_din);
      chk($sformatf("v%0d_we", i),   {28'd0, bus.dcache_we}, {28'd0, vecs[i].e_we});
      chk($sformatf("v%0d_re", i),   {31'd0, bus.dcache_re}, {31'd0, vecs[i].e_re});
      chk($sformatf("v%0d_ms", i),   {31'd0, bus.mem_stall}, {31'd0, vecs[i].e_ms});
      chk($sformatf("v%0d_mis", i),  {31'd0, bus.misaligned}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d_lv", i),   {31'd0, bus.load_valid}, 32'h0);
      chk($sformatf("v%0d_ld", i),   bus.load_data, 32'h0);
      next_cycle();
    end
    idle_in();
    @(negedge clk);
    chk("table_cnt", bus.stall_count, 32'd3);
    chk("table_state", {31'd0, bus.state_dbg}, 32'h0);

    // LH then LHU from 0x2002, response 0x8001xxxx
    do_reset();
    drive(1, 1, 4'b0000, 3'b001, 32'h0000_2002, 32'h0, 0);
    exp_q.push_back(32'hFFFF_8001);
    @(negedge clk);
    chk("lh_c1_re", {31'd0, bus.dcache_re}, 32'h1);
    chk("lh_c1_ms", {31'd0, bus.mem_stall}, 32'h1);
    chk("lh_c1_addr", bus.dcache_addr, 32'h0000_2000);
    chk("lh_c1_lv", {31'd0, bus.load_valid}, 32'h0);
    next_cycle();
    bus.dcache_dout = 32'h8001_1234;
    @(negedge clk);
    expect_load("lh_c2");
    next_cycle();
    drive(1, 1, 4'b0000, 3'b101, 32'h0000_2002, 32'h0, 0);
    exp_q.push_back(32'h0000_8001);
    @(negedge clk);
    chk("lhu_c1_re", {31'd0, bus.dcache_re}, 32'h1);
    next_cycle();
    @(negedge clk);
    expect_load("lhu_c2");
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("lh_cnt", bus.stall_count, 32'd2);

    // LW 0x3000 with the cache busy for 3 cycles in LD_WAIT
    do_reset();
    re_pulses = 0;
    drive(1, 1, 4'b0000, 3'b010, 32'h0000_3000, 32'h0, 0);
    exp_q.push_back(32'hCAFE_BABE);
    @(negedge clk);
    chk("lw_c1_ms", {31'd0, bus.mem_stall}, 32'h1);
    if (bus.dcache_re) re_pulses++;
    next_cycle();
    bus.dcache_stall = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lw_c%0d_ms", c), {31'd0, bus.mem_stall}, 32'h1);
      chk($sformatf("lw_c%0d_lv", c), {31'd0, bus.load_valid}, 32'h0);
      chk($sformatf("lw_c%0d_we", c), {28'd0, bus.dcache_we}, 32'h0);
      if (bus.dcache_re) re_pulses++;
      next_cycle();
    end
    bus.dcache_stall = 1'b0;
    bus.dcache_dout  = 32'hCAFE_BABE;
    @(negedge clk);
    if (bus.dcache_re) re_pulses++;
    expect_load("lw_c5");
    chk("lw_re_pulses", re_pulses, 32'd1);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("lw_cnt", bus.stall_count, 32'd4);

    // Reset while a load response is pending
    do_reset();
    drive(1, 1, 4'b0000, 3'b010, 32'h0000_6000, 32'h0, 0);
    @(negedge clk);
    chk("rst_c1_re", {31'd0, bus.dcache_re}, 32'h1);
    next_cycle();
    bus.dcache_stall = 1'b1;
    @(negedge clk);
    chk("rst_c2_ms", {31'd0, bus.mem_stall}, 32'h1);
    chk("rst_c2_state", {31'd0, bus.state_dbg}, 32'h1);
    next_cycle();
    reset = 1'b1;
    bus.dcache_stall = 1'b0;
    bus.dcache_dout  = 32'h1234_5678;
    @(negedge clk);
    check_all_zero("rst_held");
    next_cycle();
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    chk("rst_after_lv", {31'd0, bus.load_valid}, 32'h0);
    chk("rst_after_state", {31'd0, bus.state_dbg}, 32'h0);
    chk("rst_after_cnt", bus.stall_count, 32'h0);
    next_cycle();

    // Back-to-back LBU 0x5001, SW 0x5004, then LB 0x5003 sign extension
    drive(1, 1, 4'b0000, 3'b100, 32'h0000_5001, 32'h0, 0);
    exp_q.push_back(32'h0000_00F6);
    @(negedge clk);
    chk("lbu_c1_addr", bus.dcache_addr, 32'h0000_5000);
    next_cycle();
    bus.dcache_dout = 32'h1234_F600;
    @(negedge clk);
    expect_load("lbu_c2");
    next_cycle();
    drive(1, 0, 4'b1111, 3'b010, 32'h0000_5004, 32'h1122_3344, 0);
    @(negedge clk);
    chk("sw_we", {28'd0, bus.dcache_we}, 32'hF);
    chk("sw_addr", bus.dcache_addr, 32'h0000_5004);
    chk("sw_din", bus.dcache_din, 32'h1122_3344);
    chk("sw_ms", {31'd0, bus.mem_stall}, 32'h0);
    chk("sw_lv", {31'd0, bus.load_valid}, 32'h0);
    next_cycle();
    drive(1, 1, 4'b0000, 3'b000, 32'h0000_5003, 32'h0, 0);
    exp_q.push_back(32'hFFFF_FF80);
    next_cycle();
    bus.dcache_dout = 32'h8000_0000;
    @(negedge clk);
    expect_load("lb_c2");
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("b2b_cnt", bus.stall_count, 32'd2);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
